// File: rtl/ysyx_25040109_mem_arb.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// One transaction is outstanding at a time. Grant is round-robin between the IFU and LSU.
module ysyx_25040109_mem_arb (
    input  logic        clk,
    input  logic        rst,
    // IFU read channels
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    // LSU read channels
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    // LSU write channels
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    // Slave channels
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    output logic [31:0] mem_awaddr,
    output logic        mem_awvalid,
    input  logic        mem_awready,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    input  logic [1:0]  mem_bresp,
    input  logic        mem_bvalid,
    output logic        mem_bready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_t;

    state_t state, state_next;
    logic   last_lsu, last_lsu_next;
    logic   aw_done, aw_done_next;
    logic   w_done, w_done_next;
    logic   ar_done, ar_done_next;
    logic   lsu_req;

    assign lsu_req = lsu_awvalid | lsu_arvalid;

    // State and per-transaction handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_lsu <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            ar_done  <= 1'b0;
        end else begin
            state    <= state_next;
            last_lsu <= last_lsu_next;
            aw_done  <= aw_done_next;
            w_done   <= w_done_next;
            ar_done  <= ar_done_next;
        end
    end

    // Arbitration, channel routing and completion detection
    always_comb begin
        state_next    = state;
        last_lsu_next = last_lsu;
        aw_done_next  = aw_done;
        w_done_next   = w_done;
        ar_done_next  = ar_done;

        ifu_arready = 1'b0;
        ifu_rdata   = 32'd0;
        ifu_rresp   = 2'd0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = 32'd0;
        lsu_rresp   = 2'd0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'd0;
        lsu_bvalid  = 1'b0;
        mem_araddr  = 32'd0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awaddr  = 32'd0;
        mem_awvalid = 1'b0;
        mem_wdata   = 32'd0;
        mem_wstrb   = 4'd0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;

        case (state)
            IDLE: begin
                // IFU wins a tie only when the LSU was served last
                if (ifu_arvalid && (!lsu_req || last_lsu)) begin
                    state_next    = IFU_RD;
                    last_lsu_next = 1'b0;
                end else if (lsu_req) begin
                    state_next    = lsu_awvalid ? LSU_WR : LSU_RD;
                    last_lsu_next = 1'b1;
                end
            end
            IFU_RD: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid & ~ar_done;
                ifu_arready = mem_arready & ~ar_done;
                ifu_rdata   = mem_rdata;
                ifu_rresp   = mem_rresp;
                ifu_rvalid  = mem_rvalid;
                mem_rready  = ifu_rready;
                if (mem_arvalid && mem_arready) ar_done_next = 1'b1;
                if (mem_rvalid && mem_rready) begin
                    state_next   = IDLE;
                    ar_done_next = 1'b0;
                end
            end
            LSU_RD: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid & ~ar_done;
                lsu_arready = mem_arready & ~ar_done;
                lsu_rdata   = mem_rdata;
                lsu_rresp   = mem_rresp;
                lsu_rvalid  = mem_rvalid;
                mem_rready  = lsu_rready;
                if (mem_arvalid && mem_arready) ar_done_next = 1'b1;
                if (mem_rvalid && mem_rready) begin
                    state_next   = IDLE;
                    ar_done_next = 1'b0;
                end
            end
            LSU_WR: begin
                mem_awaddr  = lsu_awaddr;
                mem_awvalid = lsu_awvalid & ~aw_done;
                lsu_awready = mem_awready & ~aw_done;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wvalid  = lsu_wvalid & ~w_done;
                lsu_wready  = mem_wready & ~w_done;
                lsu_bresp   = mem_bresp;
                lsu_bvalid  = mem_bvalid;
                mem_bready  = lsu_bready;
                if (mem_awvalid && mem_awready) aw_done_next = 1'b1;
                if (mem_wvalid && mem_wready) w_done_next = 1'b1;
                if (mem_bvalid && mem_bready) begin
                    state_next   = IDLE;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040109_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter; the slave side is driven by hand.
module tb_ysyx_25040109_mem_arb;

    logic        clk, rst;
    logic [31:0] ifu_araddr;  logic ifu_arvalid, ifu_arready;
    logic [31:0] ifu_rdata;   logic [1:0] ifu_rresp; logic ifu_rvalid, ifu_rready;
    logic [31:0] lsu_araddr;  logic lsu_arvalid, lsu_arready;
    logic [31:0] lsu_rdata;   logic [1:0] lsu_rresp; logic lsu_rvalid, lsu_rready;
    logic [31:0] lsu_awaddr;  logic lsu_awvalid, lsu_awready;
    logic [31:0] lsu_wdata;   logic [3:0] lsu_wstrb; logic lsu_wvalid, lsu_wready;
    logic [1:0]  lsu_bresp;   logic lsu_bvalid, lsu_bready;
    logic [31:0] mem_araddr;  logic mem_arvalid, mem_arready;
    logic [31:0] mem_rdata;   logic [1:0] mem_rresp; logic mem_rvalid, mem_rready;
    logic [31:0] mem_awaddr;  logic mem_awvalid, mem_awready;
    logic [31:0] mem_wdata;   logic [3:0] mem_wstrb; logic mem_wvalid, mem_wready;
    logic [1:0]  mem_bresp;   logic mem_bvalid, mem_bready;

    int total = 0;
    int bad   = 0;

    ysyx_25040109_mem_arb dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifu_araddr = 32'd0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
        lsu_araddr = 32'd0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
        lsu_awaddr = 32'd0; lsu_awvalid = 1'b0;
        lsu_wdata = 32'd0; lsu_wstrb = 4'd0; lsu_wvalid = 1'b0; lsu_bready = 1'b0;
        mem_arready = 1'b0; mem_rdata = 32'd0; mem_rresp = 2'd0; mem_rvalid = 1'b0;
        mem_awready = 1'b0; mem_wready = 1'b0; mem_bresp = 2'd0; mem_bvalid = 1'b0;

        // Reset state: every valid and ready low
        tick(); tick();
        rst = 1'b0;
        settle();
        chk("rst_mem_arvalid", 32'(mem_arvalid), 32'd0);
        chk("rst_mem_awvalid", 32'(mem_awvalid), 32'd0);
        chk("rst_mem_wvalid",  32'(mem_wvalid),  32'd0);
        chk("rst_mem_rready",  32'(mem_rready),  32'd0);
        chk("rst_mem_bready",  32'(mem_bready),  32'd0);
        chk("rst_ifu_arready", 32'(ifu_arready), 32'd0);
        chk("rst_ifu_rvalid",  32'(ifu_rvalid),  32'd0);
        chk("rst_lsu_arready", 32'(lsu_arready), 32'd0);
        chk("rst_lsu_awready", 32'(lsu_awready), 32'd0);
        chk("rst_lsu_wready",  32'(lsu_wready),  32'd0);
        chk("rst_lsu_rvalid",  32'(lsu_rvalid),  32'd0);
        chk("rst_lsu_bvalid",  32'(lsu_bvalid),  32'd0);

        // IFU only: request in IDLE, AR one cycle later, data two cycles after AR fire
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_rready = 1'b1; mem_arready = 1'b1;
        settle();
        chk("t1_idle_arvalid", 32'(mem_arvalid), 32'd0);
        tick(); settle();
        chk("t1_arvalid",      32'(mem_arvalid), 32'd1);
        chk("t1_araddr",       mem_araddr,       32'h8000_0000);
        chk("t1_ifu_arready",  32'(ifu_arready), 32'd1);
        chk("t1_lsu_arready",  32'(lsu_arready), 32'd0);
        tick();
        ifu_arvalid = 1'b0;
        settle();
        chk("t1_ar_gated",     32'(mem_arvalid), 32'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
        settle();
        chk("t1_ifu_rvalid",   32'(ifu_rvalid),  32'd1);
        chk("t1_ifu_rdata",    ifu_rdata,        32'h0000_0413);
        chk("t1_mem_rready",   32'(mem_rready),  32'd1);
        chk("t1_lsu_rvalid",   32'(lsu_rvalid),  32'd0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        settle();
        chk("t1_idle_rvalid",  32'(ifu_rvalid),  32'd0);
        chk("t1_idle_rready",  32'(mem_rready),  32'd0);

        // Contention after reset: IFU, then LSU, then IFU
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0010;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000; lsu_rready = 1'b1;
        tick(); settle();
        chk("t2_ifu_first_addr", mem_araddr,       32'h8000_0010);
        chk("t2_ifu_arready",    32'(ifu_arready), 32'd1);
        chk("t2_lsu_blocked",    32'(lsu_arready), 32'd0);
        tick();
        ifu_araddr = 32'h8000_0014;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        settle();
        chk("t2_ar_gated",       32'(mem_arvalid), 32'd0);
        chk("t2_ifu_rdata",      ifu_rdata,        32'h1111_1111);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t2_idle_arvalid",   32'(mem_arvalid), 32'd0);
        chk("t2_idle_lsu_ready", 32'(lsu_arready), 32'd0);
        tick(); settle();
        chk("t2_lsu_addr",       mem_araddr,       32'h8000_2000);
        chk("t2_lsu_arready",    32'(lsu_arready), 32'd1);
        chk("t2_ifu_blocked",    32'(ifu_arready), 32'd0);
        tick();
        lsu_arvalid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222; mem_rresp = 2'd2;
        settle();
        chk("t2_lsu_rdata",      lsu_rdata,        32'h2222_2222);
        chk("t2_lsu_rresp",      32'(lsu_rresp),   32'd2);
        chk("t2_ifu_rvalid",     32'(ifu_rvalid),  32'd0);
        tick();
        mem_rvalid = 1'b0; mem_rresp = 2'd0;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2004;
        tick(); settle();
        chk("t2_ifu_again_addr", mem_araddr,       32'h8000_0014);
        chk("t2_lsu_wait",       32'(lsu_arready), 32'd0);
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // LSU write (AW before W) with a read also pending; IFU interleaves
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_1004;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_3000;
        mem_awready = 1'b1; mem_wready = 1'b1; lsu_bready = 1'b1;
        tick(); settle();
        chk("t3_awvalid",        32'(mem_awvalid), 32'd1);
        chk("t3_awaddr",         mem_awaddr,       32'h8000_1004);
        chk("t3_lsu_awready",    32'(lsu_awready), 32'd1);
        chk("t3_read_held",      32'(mem_arvalid), 32'd0);
        chk("t3_no_w_yet",       32'(mem_wvalid),  32'd0);
        tick();
        lsu_awvalid = 1'b0;
        lsu_wvalid = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0020;
        settle();
        chk("t3_aw_dropped",     32'(mem_awvalid), 32'd0);
        chk("t3_wvalid",         32'(mem_wvalid),  32'd1);
        chk("t3_wdata",          mem_wdata,        32'hDEAD_BEEF);
        chk("t3_wstrb",          32'(mem_wstrb),   32'hF);
        chk("t3_lsu_wready",     32'(lsu_wready),  32'd1);
        tick();
        lsu_wvalid = 1'b0;
        mem_bvalid = 1'b1; mem_bresp = 2'd1;
        settle();
        chk("t3_w_dropped",      32'(mem_wvalid),  32'd0);
        chk("t3_lsu_bvalid",     32'(lsu_bvalid),  32'd1);
        chk("t3_lsu_bresp",      32'(lsu_bresp),   32'd1);
        chk("t3_mem_bready",     32'(mem_bready),  32'd1);
        tick();
        mem_bvalid = 1'b0; mem_bresp = 2'd0;
        settle();
        chk("t3_idle_bvalid",    32'(lsu_bvalid),  32'd0);
        tick(); settle();
        chk("t3_ifu_between",    mem_araddr,       32'h8000_0020);
        chk("t3_lsu_rd_wait",    32'(lsu_arready), 32'd0);

        // Backpressure: IFU holds rready low for three cycles
        tick();
        ifu_arvalid = 1'b0; ifu_rready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("bp_mem_rready",  32'(mem_rready), 32'd0);
            chk("bp_ifu_rvalid",  32'(ifu_rvalid), 32'd1);
            tick();
        end
        ifu_rready = 1'b1;
        settle();
        chk("bp_release_rready", 32'(mem_rready),  32'd1);
        chk("bp_rdata",          ifu_rdata,        32'h3333_3333);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("bp_done",           32'(ifu_rvalid),  32'd0);
        tick(); settle();
        chk("t3_lsu_rd_addr",    mem_araddr,       32'h8000_3000);
        chk("t3_lsu_rd_arready", 32'(lsu_arready), 32'd1);
        tick();
        lsu_arvalid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
        settle();
        chk("t3_lsu_rd_data",    lsu_rdata,        32'h4444_4444);
        tick();
        mem_rvalid = 1'b0;

        // Reset in LSU_WR after AW fire, before W
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_1008;
        tick(); settle();
        chk("t4_awvalid",        32'(mem_awvalid), 32'd1);
        tick();
        lsu_awvalid = 1'b0;
        settle();
        chk("t4_aw_done",        32'(mem_awvalid), 32'd0);
        chk("t4_no_w",           32'(mem_wvalid),  32'd0);
        rst = 1'b1;
        lsu_wvalid = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'h3;
        tick(); settle();
        chk("t4_rst_wvalid",     32'(mem_wvalid),  32'd0);
        chk("t4_rst_wready",     32'(lsu_wready),  32'd0);
        chk("t4_rst_awready",    32'(lsu_awready), 32'd0);
        rst = 1'b0;
        lsu_wvalid = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0030;
        tick(); settle();
        chk("t4_ifu_arvalid",    32'(mem_arvalid), 32'd1);
        chk("t4_ifu_araddr",     mem_araddr,       32'h8000_0030);
        tick();
        ifu_arvalid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        settle();
        chk("t4_ifu_rdata",      ifu_rdata,        32'h5555_5555);
        tick();
        mem_rvalid = 1'b0;
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_100C;
        lsu_wvalid = 1'b1; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'h1;
        tick(); settle();
        chk("t4_new_awvalid",    32'(mem_awvalid), 32'd1);
        chk("t4_new_wvalid",     32'(mem_wvalid),  32'd1);
        tick();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        mem_bvalid = 1'b1;
        settle();
        chk("t4_new_bvalid",     32'(lsu_bvalid),  32'd1);
        tick();
        mem_bvalid = 1'b0;
        settle();
        chk("t4_final_bready",   32'(mem_bready),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
